serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor computing a - b, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 24 ++
 rtl/serial_subtractor_fs.sv | 28 ++
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor datapath.
//   state_t      : FSM state encodings (IDLE / RUN / DONE)
//   DEF_WIDTH    : default operand width
//   sub_overflow : two's-complement overflow of a - b, from the operand and
//                  result sign bits
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Subtraction overflows only when the operand signs differ and the result
  // sign differs from the minuend sign.
  function automatic logic sub_overflow(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb);
    return (a_msb ^ b_msb) & (r_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell, gate level.
//   A, B : minuend / subtrahend bits
//   Bin  : incoming borrow
//   D    : difference bit  A ^ B ^ Bin
//   Bout : outgoing borrow (~A & B) | (~(A ^ B) & Bin)
module full_subtractor (
  output logic Bout,
  output logic D,
  input  logic A,
  input  logic B,
  input  logic Bin
);

  logic t_xor;
  logic a_n;
  logic t_xn;
  logic g_br;
  logic p_br;

  xor u_x0 (t_xor, A, B);
  xor u_x1 (D, t_xor, Bin);
  not u_n0 (a_n, A);
  and u_a0 (g_br, a_n, B);
  not u_n1 (t_xn, t_xor);
  and u_a1 (p_br, t_xn, Bin);
  or  u_o0 (Bout, g_br, p_br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: computes a - b LSB first, one bit per clock,
// through one full-subtractor cell and a registered borrow.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : request, sampled only while idle
//   a, b       : minuend / subtrahend, captured on an accepted start
//   busy       : high while the bits are being processed
//   done       : one-cycle pulse, results valid
//   diff       : a - b mod 2^WIDTH
//   borrow_out : unsigned a < b
//   overflow   : signed overflow of a - b
// Results hold from one done pulse to the next.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor u_fs (
    .Bout (br_nxt),
    .D    (d_bit),
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Bin  (br)
  );

  // The final RUN cycle loads the outputs from the not-yet-registered result so
  // diff already contains the MSB difference bit when done rises.
  assign res_nxt = {d_bit, res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= res_nxt;
          br   <= br_nxt;
          if (cnt == CNT_LAST) begin
            // Counter holds on the last bit so it never wraps.
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_nxt;
            borrow_out <= br_nxt;
            overflow   <= sub_overflow(a_msb, b_msb, res_nxt[WIDTH-1]);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and check latency, busy length, the results
  // and that done lasts exactly one cycle.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input string tag);
    int lat;
    int bcnt;
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy_cycles"}, bcnt, W);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow_out, eb);
    check({tag, "_ovf"}, overflow, eo);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n_done;
    int gap;
    logic [W-1:0] seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rd;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow_out, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results
    run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, "t1");
    run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, "t2");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "t3a");
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "t3b");
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "zero_minus_one");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "ff_minus_ff");
    run_op(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, "max_minus_min");
    run_op(8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, "minus_zero");

    // start pulsed mid-run with different operands must be ignored
    a = 8'h35;
    b = 8'h12;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        seen = diff;
      end
    end
    check("t4_done_count", n_done, 1);
    check("t4_diff", seen, 8'h23);

    // Reset in the middle of a run aborts it and clears the outputs
    a = 8'hF0;
    b = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_diff", diff, 8'h00);
    check("t5_borrow", borrow_out, 1'b0);
    check("t5_ovf", overflow, 1'b0);
    #2 rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("t5_no_done", n_done, 0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "t5_next");

    // start held high: re-accepted each time, WIDTH+2 cycles apart
    a = 8'h10;
    b = 8'h03;
    start = 1'b1;
    gap = 0;
    while (!done && gap < 30) begin
      @(posedge clk);
      #1;
      gap++;
    end
    check("held_first_done", done, 1'b1);
    check("held_diff", diff, 8'h0D);
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!done && gap < 30);
    check("held_interval", gap, W + 2);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    // Random operands against a - b
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rd = ra - rb;
      run_op(ra, rb, rd, (ra < rb), (ra[W-1] ^ rb[W-1]) & (rd[W-1] ^ ra[W-1]), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
